// File: rtl/key_press_pkg.sv
// Shared types and defaults for the two-player key press front end.
package key_press_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 500000;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      HELD,
      RELEASE_WAIT
   } key_state_e;

endpackage

// File: rtl/key_debounce_channel.sv
// One push-button channel: 2-FF synchroniser, debounce counter and press tracker
// that emits a single-cycle pulse per accepted press.
module key_debounce_channel
   import key_press_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   input  logic enable,
   output logic pulse
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             pressed;
   key_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign s1_d    = key_n;
   assign s2_d    = s1_q;
   assign pressed = ~s2_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (pressed) begin
               state_d = PRESS_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         PRESS_WAIT: begin
            if (!pressed) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_MAX) begin
               state_d = PRESSED;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            state_d = HELD;
         end
         HELD: begin
            if (!pressed) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         RELEASE_WAIT: begin
            // A bounce back to pressed returns to HELD so it cannot re-trigger.
            if (pressed) begin
               state_d = HELD;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = HELD;
            cnt_d   = '0;
         end
      endcase
   end

   // Resetting into HELD forces a key held through reset to be released first.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         state_q <= HELD;
         cnt_q   <= '0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pulse = (state_q == PRESSED) & enable;

endmodule

// File: rtl/key_press_pulser.sv
// Player-input front end: two independent debounced channels producing
// one-cycle L/R press pulses for the tug-of-war playfield.
module key_press_pulser
   import key_press_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic key_l_n,
   input  logic key_r_n,
   input  logic enable,
   output logic L,
   output logic R
);

   key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_left (
      .clk   (clk),
      .reset (reset),
      .key_n (key_l_n),
      .enable(enable),
      .pulse (L)
   );

   key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_right (
      .clk   (clk),
      .reset (reset),
      .key_n (key_r_n),
      .enable(enable),
      .pulse (R)
   );

endmodule

// File: tb/tb_key_press_pulser.sv
// Directed bench for key_press_pulser with a short debounce window.
module tb_key_press_pulser;

   localparam int N = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic key_l_n = 1'b1;
   logic key_r_n = 1'b1;
   logic enable = 1'b1;
   logic L, R;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int l_hits, r_hits, both_hits;
   int l_first, r_first, l_last;

   key_press_pulser #(.DEBOUNCE_CYCLES(N)) dut (
      .clk    (clk),
      .reset  (reset),
      .key_l_n(key_l_n),
      .key_r_n(key_r_n),
      .enable (enable),
      .L      (L),
      .R      (R)
   );

   always #5 clk = ~clk;

   // Pulse monitor, sampling 1 ns after each rising edge.
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (L === 1'b1) begin
         if (l_hits == 0) l_first = cyc;
         l_last = cyc;
         l_hits = l_hits + 1;
      end
      if (R === 1'b1) begin
         if (r_hits == 0) r_first = cyc;
         r_hits = r_hits + 1;
      end
      if (L === 1'b1 && R === 1'b1) both_hits = both_hits + 1;
   end

   task automatic clr_counts();
      l_hits = 0; r_hits = 0; both_hits = 0;
      l_first = -1; r_first = -1; l_last = -1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      int c0;
      clr_counts();
      reset = 1'b0;
      key_l_n = 1'b0;
      wait_cyc(3);
      total++; if (L !== 1'b0) begin bad++; $display("FAIL rst_l_low: got %0b want 0", L); end
      total++; if (R !== 1'b0) begin bad++; $display("FAIL rst_r_low: got %0b want 0", R); end
      reset = 1'b1;
      wait_cyc(20);
      total++; if (l_hits !== 0) begin bad++; $display("FAIL rst_held_no_pulse: got %0d want 0", l_hits); end
      key_l_n = 1'b1;
      wait_cyc(6);
      clr_counts();
      c0 = cyc;
      key_l_n = 1'b0;
      wait_cyc(12);
      total++; if (l_hits !== 1) begin bad++; $display("FAIL rst_repress_count: got %0d want 1", l_hits); end
      total++; if (l_first !== c0 + N + 3) begin bad++; $display("FAIL rst_repress_lat: got %0d want %0d", l_first, c0 + N + 3); end
      key_l_n = 1'b1;
      wait_cyc(10);
   endtask

   task automatic test_clean_press();
      int c0;
      clr_counts();
      c0 = cyc;
      key_l_n = 1'b0;
      wait_cyc(30);
      total++; if (l_hits !== 1) begin bad++; $display("FAIL clean_count: got %0d want 1", l_hits); end
      total++; if (l_first !== c0 + N + 3) begin bad++; $display("FAIL clean_lat: got %0d want %0d", l_first, c0 + N + 3); end
      total++; if (r_hits !== 0) begin bad++; $display("FAIL clean_r_quiet: got %0d want 0", r_hits); end
      key_l_n = 1'b1;
      wait_cyc(10);
   endtask

   task automatic test_glitch();
      int c0;
      clr_counts();
      key_r_n = 1'b0;
      wait_cyc(3);
      key_r_n = 1'b1;
      wait_cyc(10);
      total++; if (r_hits !== 0) begin bad++; $display("FAIL glitch_rejected: got %0d want 0", r_hits); end
      c0 = cyc;
      key_r_n = 1'b0;
      wait_cyc(12);
      total++; if (r_hits !== 1) begin bad++; $display("FAIL glitch_then_press: got %0d want 1", r_hits); end
      total++; if (r_first !== c0 + N + 3) begin bad++; $display("FAIL glitch_then_lat: got %0d want %0d", r_first, c0 + N + 3); end
      key_r_n = 1'b1;
      wait_cyc(10);
   endtask

   task automatic test_release_bounce();
      int c0;
      clr_counts();
      key_l_n = 1'b0;
      wait_cyc(12);
      for (int i = 0; i < 5; i++) begin
         key_l_n = (i % 2 == 0);
         wait_cyc(2);
      end
      key_l_n = 1'b0;
      wait_cyc(15);
      total++; if (l_hits !== 1) begin bad++; $display("FAIL bounce_no_repeat: got %0d want 1", l_hits); end
      key_l_n = 1'b1;
      wait_cyc(8);
      c0 = cyc;
      key_l_n = 1'b0;
      wait_cyc(12);
      total++; if (l_hits !== 2) begin bad++; $display("FAIL bounce_new_press: got %0d want 2", l_hits); end
      total++; if (l_last !== c0 + N + 3) begin bad++; $display("FAIL bounce_new_lat: got %0d want %0d", l_last, c0 + N + 3); end
      key_l_n = 1'b1;
      wait_cyc(10);
   endtask

   task automatic test_simultaneous();
      int c0;
      clr_counts();
      c0 = cyc;
      key_l_n = 1'b0;
      key_r_n = 1'b0;
      wait_cyc(12);
      total++; if (both_hits !== 1) begin bad++; $display("FAIL simul_both: got %0d want 1", both_hits); end
      total++; if (l_hits !== 1) begin bad++; $display("FAIL simul_l: got %0d want 1", l_hits); end
      total++; if (r_hits !== 1) begin bad++; $display("FAIL simul_r: got %0d want 1", r_hits); end
      total++; if (r_first !== c0 + N + 3) begin bad++; $display("FAIL simul_lat: got %0d want %0d", r_first, c0 + N + 3); end
      key_l_n = 1'b1;
      key_r_n = 1'b1;
      wait_cyc(10);
   endtask

   task automatic test_enable_mask();
      int c0;
      clr_counts();
      enable = 1'b0;
      key_l_n = 1'b0;
      wait_cyc(15);
      total++; if (l_hits !== 0) begin bad++; $display("FAIL en_masked: got %0d want 0", l_hits); end
      enable = 1'b1;
      wait_cyc(5);
      total++; if (l_hits !== 0) begin bad++; $display("FAIL en_no_replay: got %0d want 0", l_hits); end
      key_l_n = 1'b1;
      wait_cyc(8);
      c0 = cyc;
      key_l_n = 1'b0;
      wait_cyc(12);
      total++; if (l_hits !== 1) begin bad++; $display("FAIL en_repress: got %0d want 1", l_hits); end
      total++; if (l_first !== c0 + N + 3) begin bad++; $display("FAIL en_repress_lat: got %0d want %0d", l_first, c0 + N + 3); end
      key_l_n = 1'b1;
      wait_cyc(10);
   endtask

   task automatic test_reset_mid_pulse();
      clr_counts();
      key_l_n = 1'b0;
      wait_cyc(N + 3);
      total++; if (L !== 1'b1) begin bad++; $display("FAIL midrst_pulse_high: got %0b want 1", L); end
      reset = 1'b0;
      wait_cyc(1);
      total++; if (L !== 1'b0) begin bad++; $display("FAIL midrst_drop: got %0b want 0", L); end
      reset = 1'b1;
      wait_cyc(10);
      total++; if (l_hits !== 1) begin bad++; $display("FAIL midrst_no_retrigger: got %0d want 1", l_hits); end
      key_l_n = 1'b1;
      wait_cyc(10);
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_glitch();
      test_release_bounce();
      test_simultaneous();
      test_enable_mask();
      test_reset_mid_pulse();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
